// File: rtl/clint_mh.sv
// Core-local interruptor: shared 64-bit mtime plus per-hart mtimecmp/msip behind a
// single-cycle register bus; drives per-hart timer and software interrupts.
module clint_mh #(
    parameter int unsigned NrHarts       = 1,
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned UseRtc        = 1,
    parameter int unsigned RtcSyncStages = 2,
    parameter int unsigned PrescaleDiv   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rtc_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [63:0]          wdata_i,
    input  logic [7:0]           be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [63:0]          rdata_o,
    output logic                 err_o,
    output logic [NrHarts-1:0]   timer_irq_o,
    output logic [NrHarts-1:0]   ipi_o
);

    localparam int unsigned DataW       = 64;
    localparam int unsigned NrBytes     = DataW / 8;
    localparam int unsigned MsipIdxW    = 12;
    localparam int unsigned CmpIdxW     = 13;
    localparam int unsigned PrescW      = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam logic [12:0] MtimeWord   = 13'h17FF;
    localparam logic [12:0] CmpBaseWord = 13'h0800;

    logic               tick;

    logic [DataW-1:0]   mtime_q, mtime_d;
    logic [DataW-1:0]   mtimecmp_q [NrHarts];
    logic [DataW-1:0]   mtimecmp_d [NrHarts];
    logic [NrHarts-1:0] msip_q, msip_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic [DataW-1:0]   rdata_q, rdata_d;
    logic [NrHarts-1:0] timer_irq_q, timer_irq_d;
    logic [NrHarts-1:0] ipi_q, ipi_d;

    logic               addr_hi_ok;
    logic               is_mtime;
    logic [12:0]        cmp_word;
    logic [NrHarts-1:0] msip_hit;
    logic [NrHarts-1:0] cmp_hit;
    logic               mapped;
    logic               wr_en;
    logic               msip_lane_be;
    logic               msip_lane_bit;
    logic [DataW-1:0]   rd_data;
    logic               unused_addr;

    // Byte-offset bits below the 32-bit word are never decoded.
    assign unused_addr = ^addr_i[1:0];

    generate
        if (UseRtc != 0) begin : g_rtc
            logic [RtcSyncStages-1:0] sync_q, sync_d;
            logic                     rtc_prev_q, rtc_prev_d;

            always_comb begin
                sync_d     = {sync_q[RtcSyncStages-2:0], rtc_i};
                rtc_prev_d = sync_q[RtcSyncStages-1];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q     <= '0;
                    rtc_prev_q <= 1'b0;
                end else begin
                    sync_q     <= sync_d;
                    rtc_prev_q <= rtc_prev_d;
                end
            end

            assign tick = sync_q[RtcSyncStages-1] & ~rtc_prev_q;
        end else begin : g_presc
            logic [PrescW-1:0] presc_q, presc_d;
            logic              wrap;
            logic              unused_rtc;

            assign unused_rtc = rtc_i;

            always_comb begin
                wrap    = (presc_q == PrescW'(PrescaleDiv - 1));
                presc_d = wrap ? '0 : presc_q + PrescW'(1);
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_d;
                end
            end

            assign tick = wrap;
        end
    endgenerate

    // Address decode; mtime wins over the top of the mtimecmp window.
    always_comb begin
        addr_hi_ok = ((addr_i >> 16) == '0);
        is_mtime   = addr_hi_ok && (addr_i[15:3] == MtimeWord);
        cmp_word   = addr_i[15:3] - CmpBaseWord;
        msip_hit   = '0;
        cmp_hit    = '0;
        for (int unsigned h = 0; h < NrHarts; h++) begin
            msip_hit[h] = addr_hi_ok && (addr_i[15:14] == 2'b00)
                          && (addr_i[13:2] == MsipIdxW'(h));
            cmp_hit[h]  = addr_hi_ok && !is_mtime && (addr_i[15:3] >= CmpBaseWord)
                          && (cmp_word == CmpIdxW'(h));
        end
        mapped = is_mtime || (|msip_hit) || (|cmp_hit);
    end

    always_comb begin
        rd_data = '0;
        if (is_mtime) begin
            rd_data = mtime_q;
        end
        for (int unsigned h = 0; h < NrHarts; h++) begin
            if (msip_hit[h]) begin
                rd_data = addr_i[2] ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
            end
            if (cmp_hit[h]) begin
                rd_data = mtimecmp_q[h];
            end
        end

        wr_en         = req_i && we_i;
        msip_lane_be  = addr_i[2] ? be_i[4] : be_i[0];
        msip_lane_bit = addr_i[2] ? wdata_i[32] : wdata_i[0];

        // Enabled write bytes override the ticked value; the rest keep the increment.
        mtime_d = mtime_q + DataW'(tick);
        for (int unsigned b = 0; b < NrBytes; b++) begin
            if (wr_en && is_mtime && be_i[b]) begin
                mtime_d[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end

        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        for (int unsigned h = 0; h < NrHarts; h++) begin
            if (wr_en && msip_hit[h] && msip_lane_be) begin
                msip_d[h] = msip_lane_bit;
            end
            for (int unsigned b = 0; b < NrBytes; b++) begin
                if (wr_en && cmp_hit[h] && be_i[b]) begin
                    mtimecmp_d[h][8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
            timer_irq_d[h] = (mtime_q >= mtimecmp_q[h]);
        end
        ipi_d = msip_q;

        rvalid_d = req_i;
        err_d    = req_i && !mapped;
        rdata_d  = (req_i && !we_i && mapped) ? rd_data : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q <= '0;
            msip_q  <= '0;
            for (int unsigned h = 0; h < NrHarts; h++) begin
                mtimecmp_q[h] <= '1;
            end
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            timer_irq_q <= '0;
            ipi_q       <= '0;
        end else begin
            mtime_q     <= mtime_d;
            msip_q      <= msip_d;
            mtimecmp_q  <= mtimecmp_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            timer_irq_q <= timer_irq_d;
            ipi_q       <= ipi_d;
        end
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign timer_irq_o = timer_irq_q;
    assign ipi_o       = ipi_q;

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: a 4-hart prescaled instance checked against a reference model
// and a 2-hart RTC instance checked against the RTC latency.
module tb_clint_mh;

    typedef struct packed {
        logic        cd;
        logic        err;
        logic [63:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rtc_a;
    logic        rtc_b;
    logic        req_a;
    logic        req_b;
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;

    logic        gnt_a, rvalid_a, err_a;
    logic [63:0] rdata_a;
    logic [3:0]  irq_a, ipi_a;
    logic        gnt_b, rvalid_b, err_b;
    logic [63:0] rdata_b;
    logic [1:0]  irq_b, ipi_b;

    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;

    rsp_t q_a[$];
    rsp_t q_b[$];

    // Reference state of the prescaled instance.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp [4];
    logic [3:0]  m_msip;
    logic [1:0]  m_ph;
    logic [3:0]  exp_irq;
    logic [3:0]  exp_ipi;
    logic        req_a_d;
    logic        req_b_d;

    always #5 clk = ~clk;

    clint_mh #(
        .NrHarts(4), .AddrWidth(16), .UseRtc(0), .RtcSyncStages(2), .PrescaleDiv(4)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .rtc_i(rtc_a), .req_i(req_a), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a), .timer_irq_o(irq_a), .ipi_o(ipi_a)
    );

    clint_mh #(
        .NrHarts(2), .AddrWidth(16), .UseRtc(1), .RtcSyncStages(2), .PrescaleDiv(1)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .rtc_i(rtc_b), .req_i(req_b), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b), .timer_irq_o(irq_b), .ipi_o(ipi_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] b);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // -1 unmapped, 0..3 msip[h], 4..7 mtimecmp[h-4], 8 mtime (4-hart map).
    function automatic int dec(input logic [15:0] a);
        if (a[15:3] == 13'h17FF) return 8;
        if (a < 16'h0010) return int'(a[3:2]);
        if (a >= 16'h4000 && a < 16'h4020) return 4 + int'(a[4:3]);
        return -1;
    endfunction

    function automatic rsp_t mdl_rd(input logic w, input logic [15:0] a);
        int   k;
        rsp_t r;
        k      = dec(a);
        r.cd   = !w;
        r.err  = (k < 0);
        r.data = '0;
        if (!w) begin
            if (k == 8) r.data = m_mtime;
            else if (k >= 4) r.data = m_cmp[k-4];
            else if (k >= 0) r.data = a[2] ? {31'b0, m_msip[k], 32'b0} : 64'(m_msip[k]);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        req_a_d <= req_a & ~rst;
        req_b_d <= req_b & ~rst;
        if (rst) begin
            m_mtime <= '0;
            for (int h = 0; h < 4; h++) m_cmp[h] <= '1;
            m_msip  <= '0;
            m_ph    <= '0;
            exp_irq <= '0;
            exp_ipi <= '0;
        end else begin
            for (int h = 0; h < 4; h++) exp_irq[h] <= (m_mtime >= m_cmp[h]);
            exp_ipi <= m_msip;
            m_ph    <= m_ph + 2'd1;
            if (req_a && we && dec(addr) == 8)
                m_mtime <= merge(m_mtime + 64'(m_ph == 2'd3), wdata, be);
            else
                m_mtime <= m_mtime + 64'(m_ph == 2'd3);
            for (int h = 0; h < 4; h++) begin
                if (req_a && we && dec(addr) == h && (addr[2] ? be[4] : be[0]))
                    m_msip[h] <= addr[2] ? wdata[32] : wdata[0];
                if (req_a && we && dec(addr) == 4 + h)
                    m_cmp[h] <= merge(m_cmp[h], wdata, be);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_a", 64'(gnt_a), 64'(req_a));
            check("rvalid_a", 64'(rvalid_a), 64'(req_a_d));
            check("irq_a", 64'(irq_a), 64'(exp_irq));
            check("ipi_a", 64'(ipi_a), 64'(exp_ipi));
            if (rvalid_a && q_a.size() > 0) begin
                check("err_a", 64'(err_a), 64'(q_a[0].err));
                if (q_a[0].cd || q_a[0].err) check("rdata_a", rdata_a, q_a[0].data);
                void'(q_a.pop_front());
            end
            check("gnt_b", 64'(gnt_b), 64'(req_b));
            check("rvalid_b", 64'(rvalid_b), 64'(req_b_d));
            check("irq_b", 64'(irq_b), 64'h0);
            check("ipi_b", 64'(ipi_b), 64'h0);
            if (rvalid_b && q_b.size() > 0) begin
                check("err_b", 64'(err_b), 64'(q_b[0].err));
                if (q_b[0].cd) check("rdata_b", rdata_b, q_b[0].data);
                void'(q_b.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus cycle on instance a (sel=0, model expectation) or b (sel=1, given expectation).
    task automatic bus(input bit sel, input logic w, input logic [15:0] a,
                       input logic [63:0] d, input logic [7:0] b, input logic [63:0] exp_b);
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        if (!sel) begin
            req_a = 1'b1;
            q_a.push_back(mdl_rd(w, a));
        end else begin
            req_b = 1'b1;
            q_b.push_back(rsp_t'{cd: ~w, err: 1'b0, data: exp_b});
        end
        @(posedge clk);
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        rtc_a = 1'b0;
        rtc_b = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        check("rst_rdata_a", rdata_a, 64'h0);
        check("rst_err_a", 64'(err_a), 64'h0);
        check("rst_rdata_b", rdata_b, 64'h0);
        check("rst_err_b", 64'(err_b), 64'h0);

        // Reset values seen through the idle RTC instance.
        bus(1, 1'b0, 16'hBFF8, '0, '0, 64'h0);
        bus(1, 1'b0, 16'h4000, '0, '0, 64'hFFFF_FFFF_FFFF_FFFF);
        bus(1, 1'b0, 16'h0000, '0, '0, 64'h0);
        bus(0, 1'b0, 16'h4018, '0, '0, '0);

        // Software interrupts and msip lane handling.
        bus(0, 1'b1, 16'h0008, 64'hFFFF_FFFF, 8'h0F, '0);
        idle(1);
        check("ipi_hart2", 64'(ipi_a), 64'h4);
        bus(0, 1'b0, 16'h0008, '0, '0, '0);
        bus(0, 1'b1, 16'h0004, 64'h1_0000_0000, 8'h10, '0);
        bus(0, 1'b0, 16'h0004, '0, '0, '0);
        bus(0, 1'b1, 16'h000C, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, '0);
        bus(0, 1'b0, 16'h000C, '0, '0, '0);
        bus(0, 1'b1, 16'h0008, 64'h0, 8'h0F, '0);
        bus(0, 1'b1, 16'h0004, 64'h0, 8'hF0, '0);
        idle(3);

        // Timer compare rising and falling.
        bus(0, 1'b1, 16'hBFF8, 64'h0, 8'hFF, '0);
        bus(0, 1'b1, 16'h4000, 64'd3, 8'hFF, '0);
        idle(20);
        bus(0, 1'b1, 16'h4000, 64'd10, 8'hFF, '0);
        idle(30);
        bus(0, 1'b0, 16'h4000, '0, '0, '0);
        bus(0, 1'b0, 16'hBFF8, '0, '0, '0);

        // mtime wrap, then an upper-half write landing on a tick.
        bus(0, 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, '0);
        idle(5);
        bus(0, 1'b0, 16'hBFF8, '0, '0, '0);
        for (int i = 0; i < 8 && m_ph != 2'd3; i++) idle(1);
        bus(0, 1'b1, 16'hBFF8, 64'h1234_5678_DEAD_BEEF, 8'hF0, '0);
        bus(0, 1'b0, 16'hBFF8, '0, '0, '0);

        // Unmapped accesses.
        bus(0, 1'b0, 16'h8000, '0, '0, '0);
        bus(0, 1'b1, 16'h5000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, '0);
        bus(0, 1'b0, 16'h4020, '0, '0, '0);
        bus(0, 1'b1, 16'h0010, 64'h1, 8'hFF, '0);
        for (int h = 0; h < 4; h++) bus(0, 1'b0, 16'h4000 + 16'(8 * h), '0, '0, '0);
        bus(0, 1'b0, 16'h0000, '0, '0, '0);

        // Reset on the edge that would accept a write: no response, no write.
        we    = 1'b1;
        addr  = 16'h4008;
        wdata = 64'h55;
        be    = 8'hFF;
        req_a = 1'b1;
        rst   = 1'b1;
        idle(1);
        req_a = 1'b0;
        idle(1);
        rst = 1'b0;
        bus(0, 1'b0, 16'h4008, '0, '0, '0);
        bus(0, 1'b0, 16'h4000, '0, '0, '0);
        bus(0, 1'b0, 16'hBFF8, '0, '0, '0);

        // RTC at 1/10 clock rate: each edge shows up three cycles later.
        for (int e = 1; e <= 5; e++) begin
            rtc_b = 1'b1;
            for (int k = 0; k < 10; k++) begin
                if (k == 5) rtc_b = 1'b0;
                bus(1, 1'b0, 16'hBFF8, '0, '0, (k < 3) ? 64'(e - 1) : 64'(e));
            end
        end
        idle(4);
        bus(1, 1'b0, 16'hBFF8, '0, '0, 64'd5);

        idle(3);
        check("q_a_drained", 64'(q_a.size()), 64'h0);
        check("q_b_drained", 64'(q_b.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
